mem_stage_mw: RTL

Memory-stage datapath and M/W pipeline register of the five-stage MIPS core. It holds the data memory, executes `sw` writes and `lw` reads using the M-stage control outputs, and selects the register write-back value and destination. These are registered into the W stage together with PC, instruction and the decremented Tnew. It sits between the M-stage control decoder (which supplies `mem_write_enable`, `Tnew`, `fw_ad_op`, `fw_data_op`) and the W-stage register-file write port.

---
 rtl/mem_stage_mw_if.sv | 35 +++
 rtl/mem_stage_mw.sv | 137 +++++++++++++
 2 files changed

// File: rtl/mem_stage_mw_if.sv
// rtl/mem_stage_mw_if.sv - M-stage inputs and W-stage outputs of the memory stage
interface mem_stage_mw_if;
    logic [31:0] M_pc;
    logic [31:0] M_instr;
    logic [31:0] M_alu_result;
    logic [31:0] M_rt_data;
    logic        M_mem_write_enable;
    logic [1:0]  M_fw_ad_op;
    logic [1:0]  M_fw_data_op;
    logic [1:0]  M_Tnew;

    logic [31:0] W_pc;
    logic [31:0] W_instr;
    logic [4:0]  W_reg_addr;
    logic [31:0] W_reg_data;
    logic        W_reg_we;
    logic [1:0]  W_Tnew;
    logic        addr_error;

    // Upstream pipeline drives M fields and observes W fields.
    modport master (
        output M_pc, M_instr, M_alu_result, M_rt_data,
               M_mem_write_enable, M_fw_ad_op, M_fw_data_op, M_Tnew,
        input  W_pc, W_instr, W_reg_addr, W_reg_data, W_reg_we, W_Tnew,
               addr_error
    );

    // The memory stage consumes M fields and produces W fields.
    modport slave (
        input  M_pc, M_instr, M_alu_result, M_rt_data,
               M_mem_write_enable, M_fw_ad_op, M_fw_data_op, M_Tnew,
        output W_pc, W_instr, W_reg_addr, W_reg_data, W_reg_we, W_Tnew,
               addr_error
    );
endinterface

// File: rtl/mem_stage_mw.sv
// rtl/mem_stage_mw.sv - MIPS memory stage, data memory and M/W register; optional store trace under DM_TRACE_EN
module mem_stage_mw #(
    parameter int          DEPTH_WORDS = 3072,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    mem_stage_mw_if.slave m
);

    localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;

    localparam logic [1:0] AD_RD   = 2'b00;
    localparam logic [1:0] AD_RT   = 2'b01;
    localparam logic [1:0] AD_RA   = 2'b10;

    localparam logic [1:0] SRC_ALU = 2'b00;
    localparam logic [1:0] SRC_MEM = 2'b01;
    localparam logic [1:0] SRC_PC8 = 2'b10;
    localparam logic [1:0] SRC_NONE = 2'b11;

    logic [31:0]      mem [DEPTH_WORDS];

    logic [31:0]      byte_offset;
    logic             in_range;
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      load_data;
    logic             store_fire;
    logic             bad_access;
    logic [4:0]       dest_addr;
    logic [31:0]      wb_data;
    logic             wb_we;
    logic [1:0]       tnew_next;

    // Address decode: low two bits are dropped, so misaligned accesses hit the containing word.
    always_comb begin
        byte_offset = m.M_alu_result - ADDR_BASE;
        in_range    = ({1'b0, byte_offset} < SPAN_BYTES);
        word_idx    = byte_offset[IDX_W+1:2];
        store_fire  = m.M_mem_write_enable && in_range;
        bad_access  = !in_range && (m.M_mem_write_enable || (m.M_fw_data_op == SRC_MEM));
    end

    // Combinational read; an out-of-range word reads as zero rather than aliasing.
    always_comb begin
        load_data = 32'h0;
        if (in_range) begin
            load_data = mem[word_idx];
        end
    end

    // Destination register selection.
    always_comb begin
        dest_addr = 5'd0;
        case (m.M_fw_ad_op)
            AD_RD:   dest_addr = m.M_instr[15:11];
            AD_RT:   dest_addr = m.M_instr[20:16];
            AD_RA:   dest_addr = 5'd31;
            default: dest_addr = 5'd0;
        endcase
    end

    // Write-back value selection; $0 is never a write target.
    always_comb begin
        wb_data = 32'h0;
        case (m.M_fw_data_op)
            SRC_ALU: wb_data = m.M_alu_result;
            SRC_MEM: wb_data = load_data;
            SRC_PC8: wb_data = m.M_pc + 32'd8;
            default: wb_data = 32'h0;
        endcase
        wb_we = (m.M_fw_data_op != SRC_NONE) && (dest_addr != 5'd0);
    end

    // One stage closer to ready; the 2'b11 no-result sentinel passes through unchanged.
    always_comb begin
        tnew_next = 2'b11;
        case (m.M_Tnew)
            2'd0:    tnew_next = 2'd0;
            2'd1:    tnew_next = 2'd0;
            2'd2:    tnew_next = 2'd1;
            default: tnew_next = 2'b11;
        endcase
    end

    // Data memory: cleared asynchronously so a store pending at reset is lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (store_fire) begin
            mem[word_idx] <= m.M_rt_data;
        end
    end

    // M/W pipeline register: loads every cycle, there is no stall or flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m.W_pc       <= 32'h0;
            m.W_instr    <= 32'h0;
            m.W_reg_addr <= 5'd0;
            m.W_reg_data <= 32'h0;
            m.W_reg_we   <= 1'b0;
            m.W_Tnew     <= 2'b11;
        end else begin
            m.W_pc       <= m.M_pc;
            m.W_instr    <= m.M_instr;
            m.W_reg_addr <= dest_addr;
            m.W_reg_data <= wb_data;
            m.W_reg_we   <= wb_we;
            m.W_Tnew     <= tnew_next;
        end
    end

    // Sticky out-of-range flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m.addr_error <= 1'b0;
        end else if (bad_access) begin
            m.addr_error <= 1'b1;
        end
    end

`ifdef DM_TRACE_EN
    // Store trace, emitted only for stores that actually write the array.
    always @(posedge clk) begin
        if (reset && store_fire) begin
            $display("%d@%h: *%h <= %h", $time, m.M_pc,
                     {m.M_alu_result[31:2], 2'b00}, m.M_rt_data);
        end
    end
`else
`endif

endmodule
